fcp6_slave: RTL and testbench

Responder end of the FCP6 two-wire-pair link: a 2-bit `data` bus, single `ack` line and 2-bit `ctrl` bus shared with the bus master. The block decodes the 8-bit header (7-bit address plus R/W bit) and acknowledges only its own address. On a write it receives one data byte and hands it to local logic. On a read it fetches one byte from local logic, drives it onto the bus, then collects the master's acknowledge. It sits between the shared FCP6 pins and a register file or peripheral.

---
 rtl/fcp6_slave.sv | 200 ++++++++++++++++++++
 tb/tb_fcp6_slave.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fcp6_slave.sv
// FCP6 responder: decodes the 8-bit header, accepts one written byte or returns one read byte,
// and drives the shared data/ack/ctrl pins from falling-edge enable registers.
module fcp6_slave #(
    parameter logic [6:0]  ADDR    = 7'h4C,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire  [1:0] data_io,
    inout  wire        ack_io,
    inout  wire  [1:0] ctrl_io,
    input  logic [7:0] rd_data_i,
    output logic       rd_req_o,
    output logic [7:0] wr_data_o,
    output logic       wr_valid_o,
    output logic       rd_done_o,
    output logic       busy_o,
    output logic       error_o
);

    localparam int unsigned TO_W   = 8;
    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_HDR, S_ADDR, S_HACK, S_WR, S_WACK, S_RD, S_RACK, S_SKIP, S_END
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [7:0]      hdr_q, hdr_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      wr_data_q, wr_data_d;
    logic [TO_W-1:0] to_q, to_d;
    logic            rd_req_q, rd_req_d;
    logic            wr_valid_q, wr_valid_d;
    logic            rd_done_q, rd_done_d;
    logic            error_q, error_d;
    logic            busy_q;
    logic            data_en_q, ack_en_q, ctrl_en_q;
    logic [1:0]      data_out_q;

    logic ctrl_master_c;
    logic ctrl_idle_c;
    assign ctrl_master_c = (ctrl_io == 2'b01);
    assign ctrl_idle_c   = (ctrl_io == 2'b11) || (ctrl_io == 2'b00);

    // Rising-edge state and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 2'd0;
            hdr_q      <= 8'd0;
            shift_q    <= 8'd0;
            wr_data_q  <= 8'd0;
            to_q       <= '0;
            rd_req_q   <= 1'b0;
            wr_valid_q <= 1'b0;
            rd_done_q  <= 1'b0;
            error_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hdr_q      <= hdr_d;
            shift_q    <= shift_d;
            wr_data_q  <= wr_data_d;
            to_q       <= to_d;
            rd_req_q   <= rd_req_d;
            wr_valid_q <= wr_valid_d;
            rd_done_q  <= rd_done_d;
            error_q    <= error_d;
            busy_q     <= (state_d != S_IDLE);
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hdr_d      = hdr_q;
        shift_d    = shift_q;
        wr_data_d  = wr_data_q;
        to_d       = to_q;
        rd_req_d   = 1'b0;
        wr_valid_d = 1'b0;
        rd_done_d  = 1'b0;
        error_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ctrl_master_c) begin
                    hdr_d   = {6'd0, data_io};
                    cnt_d   = 2'd1;
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                if (ctrl_master_c) begin
                    hdr_d = {hdr_q[5:0], data_io};
                    cnt_d = 2'(cnt_q + 2'd1);
                    if (cnt_q == 2'd3) state_d = S_ADDR;
                end else begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_ADDR: begin
                cnt_d   = 2'd0;
                state_d = (hdr_q[7:1] == ADDR) ? S_HACK : S_SKIP;
            end
            S_HACK: begin
                cnt_d = 2'd0;
                if (hdr_q[0]) begin
                    state_d = S_WR;
                end else begin
                    shift_d  = rd_data_i;
                    rd_req_d = 1'b1;
                    state_d  = S_RD;
                end
            end
            S_WR: begin
                if (ctrl_master_c) begin
                    shift_d = {shift_q[5:0], data_io};
                    cnt_d   = 2'(cnt_q + 2'd1);
                    if (cnt_q == 2'd3) begin
                        wr_data_d  = {shift_q[5:0], data_io};
                        wr_valid_d = 1'b1;
                        state_d    = S_WACK;
                    end
                end else begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_WACK: begin
                to_d    = '0;
                state_d = S_END;
            end
            S_RD: begin
                shift_d = {shift_q[5:0], 2'b00};
                cnt_d   = 2'(cnt_q + 2'd1);
                if (cnt_q == 2'd3) begin
                    to_d    = '0;
                    state_d = S_RACK;
                end
            end
            S_RACK: begin
                if (ack_io == 1'b0) begin
                    rd_done_d = 1'b1;
                    to_d      = '0;
                    state_d   = S_END;
                end else if (to_q >= TO_LIM) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end else if (to_q != '1) begin
                    to_d = TO_W'(to_q + 1'b1);
                end
            end
            S_SKIP: begin
                if (ctrl_idle_c) state_d = S_IDLE;
            end
            S_END: begin
                if (ctrl_idle_c) begin
                    state_d = S_IDLE;
                end else if (to_q >= TO_LIM) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end else if (to_q != '1) begin
                    to_d = TO_W'(to_q + 1'b1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pin enables and read dibit update on the falling edge; reset releases the pins at once
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            data_en_q  <= 1'b0;
            ack_en_q   <= 1'b0;
            ctrl_en_q  <= 1'b0;
            data_out_q <= 2'b00;
        end else begin
            data_en_q  <= (state_q == S_RD);
            ctrl_en_q  <= (state_q == S_RD);
            ack_en_q   <= (state_q == S_HACK) || (state_q == S_WACK);
            data_out_q <= shift_q[7:6];
        end
    end

    assign data_io = data_en_q ? data_out_q : 2'bzz;
    assign ctrl_io = ctrl_en_q ? 2'b10 : 2'bzz;
    assign ack_io  = ack_en_q ? 1'b0 : 1'bz;

    assign rd_req_o   = rd_req_q;
    assign wr_data_o  = wr_data_q;
    assign wr_valid_o = wr_valid_q;
    assign rd_done_o  = rd_done_q;
    assign busy_o     = busy_q;
    assign error_o    = error_q;

endmodule

// File: tb/tb_fcp6_slave.sv
// Directed bench for fcp6_slave: a bus-master model drives frames on the falling edge and
// checks pins and local-side outputs just after each rising edge.
module tb_fcp6_slave;

    logic       clk;
    logic       rst;
    tri0  [1:0] data_w;
    tri1        ack_w;
    tri0  [1:0] ctrl_w;
    logic [7:0] rd_data;
    logic       rd_req;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       rd_done;
    logic       busy;
    logic       error;

    logic       m_data_en, m_ctrl_en, m_ack_en;
    logic [1:0] m_data, m_ctrl;

    int checks = 0;
    int errors = 0;
    int n_rr = 0, n_wv = 0, n_rd = 0, n_err = 0;
    int n_sack = 0, n_sctrl = 0, n_sdata = 0;
    int s_rr, s_wv, s_rd, s_err, s_sack, s_sctrl, s_sdata;

    assign data_w = m_data_en ? m_data : 2'bzz;
    assign ctrl_w = m_ctrl_en ? m_ctrl : 2'bzz;
    assign ack_w  = m_ack_en ? 1'b0 : 1'bz;

    fcp6_slave #(.ADDR(7'h4C), .TIMEOUT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_io    (data_w),
        .ack_io     (ack_w),
        .ctrl_io    (ctrl_w),
        .rd_data_i  (rd_data),
        .rd_req_o   (rd_req),
        .wr_data_o  (wr_data),
        .wr_valid_o (wr_valid),
        .rd_done_o  (rd_done),
        .busy_o     (busy),
        .error_o    (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Pulse counters sampled mid-cycle; slave pin activity sampled at the rising edge
    always @(negedge clk) begin
        if (rd_req)   n_rr  = n_rr + 1;
        if (wr_valid) n_wv  = n_wv + 1;
        if (rd_done)  n_rd  = n_rd + 1;
        if (error)    n_err = n_err + 1;
    end

    always @(posedge clk) begin
        if (ack_w === 1'b0 && !m_ack_en)   n_sack  = n_sack + 1;
        if (ctrl_w === 2'b10)              n_sctrl = n_sctrl + 1;
        if (!m_data_en && data_w !== 2'b00) n_sdata = n_sdata + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One bus cycle: master updates on the falling edge, returns just after the next rising edge
    task automatic bus(input logic ce, input logic [1:0] c, input logic de, input logic [1:0] d,
                       input logic ae);
        @(negedge clk);
        m_ctrl_en = ce;
        m_ctrl    = c;
        m_data_en = de;
        m_data    = d;
        m_ack_en  = ae;
        @(posedge clk);
        #1;
    endtask

    task automatic hdr(input logic [7:0] h);
        for (int i = 0; i < 4; i++) bus(1'b1, 2'b01, 1'b1, 2'(h >> (6 - 2 * i)), 1'b0);
    endtask

    task automatic snap();
        s_rr = n_rr; s_wv = n_wv; s_rd = n_rd; s_err = n_err;
        s_sack = n_sack; s_sctrl = n_sctrl; s_sdata = n_sdata;
    endtask

    task automatic write_frame(input logic [7:0] h, input logic [7:0] d);
        snap();
        hdr(h);
        chk("wr_busy_hdr", 32'(busy), 32'd1);
        bus(1'b1, 2'b01, 1'b0, 2'b00, 1'b0);
        chk("wr_ack_before_hack", 32'(ack_w), 32'd1);
        bus(1'b1, 2'b01, 1'b0, 2'b00, 1'b0);
        chk("wr_hack_s5", 32'(ack_w), 32'd0);
        for (int i = 0; i < 4; i++) bus(1'b1, 2'b01, 1'b1, 2'(d >> (6 - 2 * i)), 1'b0);
        chk("wr_valid_s9", 32'(wr_valid), 32'd1);
        chk("wr_data_s9", 32'(wr_data), 32'(d));
        bus(1'b1, 2'b01, 1'b0, 2'b00, 1'b0);
        chk("wr_wack_s10", 32'(ack_w), 32'd0);
        chk("wr_valid_low_s10", 32'(wr_valid), 32'd0);
        bus(1'b1, 2'b11, 1'b0, 2'b00, 1'b0);
        chk("wr_busy_end", 32'(busy), 32'd0);
        bus(1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        chk("wr_valid_count", 32'(n_wv - s_wv), 32'd1);
        chk("wr_no_error", 32'(n_err - s_err), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        rd_data = 8'h00;
        m_data_en = 1'b0; m_ctrl_en = 1'b0; m_ack_en = 1'b0;
        m_data = 2'b00; m_ctrl = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_pulses", 32'({rd_req, wr_valid, rd_done, error}), 32'd0);
        chk("rst_ack_released", 32'(ack_w), 32'd1);
        chk("rst_ctrl_released", 32'(ctrl_w), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus(1'b0, 2'b00, 1'b0, 2'b00, 1'b0);

        // Write 0xA5 to 0x4C
        write_frame(8'h99, 8'hA5);

        // Read 0x3C from 0x4C with master ACK at S10
        snap();
        rd_data = 8'h3C;
        hdr(8'h98);
        bus(1'b1, 2'b01, 1'b0, 2'b00, 1'b0);
        bus(1'b1, 2'b01, 1'b0, 2'b00, 1'b0);
        chk("rd_hack_s5", 32'(ack_w), 32'd0);
        chk("rd_req_s5", 32'(rd_req), 32'd1);
        bus(1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        chk("rd_ctrl_s6", 32'(ctrl_w), 32'h2);
        chk("rd_data_s6", 32'(data_w), 32'd0);
        chk("rd_req_low_s6", 32'(rd_req), 32'd0);
        bus(1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        chk("rd_data_s7", 32'(data_w), 32'd3);
        bus(1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        chk("rd_data_s8", 32'(data_w), 32'd3);
        bus(1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        chk("rd_data_s9", 32'(data_w), 32'd0);
        chk("rd_ctrl_s9", 32'(ctrl_w), 32'h2);
        bus(1'b0, 2'b00, 1'b0, 2'b00, 1'b1);
        chk("rd_done_s10", 32'(rd_done), 32'd1);
        chk("rd_ctrl_released", 32'(ctrl_w), 32'd0);
        bus(1'b1, 2'b11, 1'b0, 2'b00, 1'b0);
        chk("rd_busy_end", 32'(busy), 32'd0);
        bus(1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        chk("rd_req_count", 32'(n_rr - s_rr), 32'd1);
        chk("rd_done_count", 32'(n_rd - s_rd), 32'd1);
        chk("rd_no_error", 32'(n_err - s_err), 32'd0);

        // Address mismatch 0x21: slave must stay silent until end of frame
        snap();
        hdr(8'h21);
        for (int i = 0; i < 4; i++) bus(1'b1, 2'b01, 1'b0, 2'b00, 1'b0);
        chk("skip_busy", 32'(busy), 32'd1);
        bus(1'b1, 2'b11, 1'b0, 2'b00, 1'b0);
        chk("skip_idle", 32'(busy), 32'd0);
        bus(1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        chk("skip_no_ack", 32'(n_sack - s_sack), 32'd0);
        chk("skip_no_ctrl", 32'(n_sctrl - s_sctrl), 32'd0);
        chk("skip_no_data", 32'(n_sdata - s_sdata), 32'd0);
        chk("skip_no_pulses", 32'((n_rr - s_rr) + (n_wv - s_wv) + (n_rd - s_rd) + (n_err - s_err)),
            32'd0);

        // Read with no master ACK: error at the 16th RACK sample (S25)
        snap();
        rd_data = 8'h5A;
        hdr(8'h98);
        bus(1'b1, 2'b01, 1'b0, 2'b00, 1'b0);
        bus(1'b1, 2'b01, 1'b0, 2'b00, 1'b0);
        chk("to_rd_req", 32'(rd_req), 32'd1);
        for (int i = 0; i < 4; i++) bus(1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        for (int k = 10; k < 25; k++) bus(1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        chk("to_no_error_yet", 32'(n_err - s_err), 32'd0);
        chk("to_busy_waiting", 32'(busy), 32'd1);
        bus(1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        chk("to_error_s25", 32'(error), 32'd1);
        chk("to_idle", 32'(busy), 32'd0);
        bus(1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        chk("to_error_one_cycle", 32'(error), 32'd0);
        chk("to_no_rd_done", 32'(n_rd - s_rd), 32'd0);

        // Abort mid-write after two data dibits
        snap();
        hdr(8'h99);
        bus(1'b1, 2'b01, 1'b0, 2'b00, 1'b0);
        bus(1'b1, 2'b01, 1'b0, 2'b00, 1'b0);
        bus(1'b1, 2'b01, 1'b1, 2'b00, 1'b0);
        bus(1'b1, 2'b01, 1'b1, 2'b11, 1'b0);
        bus(1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        chk("abort_error", 32'(error), 32'd1);
        chk("abort_idle", 32'(busy), 32'd0);
        chk("abort_wr_data_kept", 32'(wr_data), 32'hA5);
        bus(1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        chk("abort_no_wr_valid", 32'(n_wv - s_wv), 32'd0);

        // Reset during RD releases pins immediately; a new write then completes
        rd_data = 8'hFF;
        hdr(8'h98);
        bus(1'b1, 2'b01, 1'b0, 2'b00, 1'b0);
        bus(1'b1, 2'b01, 1'b0, 2'b00, 1'b0);
        bus(1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        chk("mrst_ctrl_driven", 32'(ctrl_w), 32'h2);
        chk("mrst_data_driven", 32'(data_w), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("mrst_ctrl_released", 32'(ctrl_w), 32'd0);
        chk("mrst_data_released", 32'(data_w), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_wr_data", 32'(wr_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus(1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
        write_frame(8'h99, 8'h3C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
